// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/result handshake bundle for div_sequencer
//
// in_valid/in_ready/in_op/in_src1/in_src2 : request channel from EX
// cancel                                  : pipeline flush
// out_valid/out_ready/out_result          : result channel to MEM
// busy                                    : sequencer not idle
interface div_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        cancel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  modport master (
    output in_valid, in_op, in_src1, in_src2, cancel, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, cancel, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring 32-bit divide/modulo sequencer
//
// clk    : sole clock, rising edge
// resetn : synchronous active-low reset
// bus    : div_sequencer_if.slave (request, cancel, result, busy)
// in_op one-hot: bit0 div_w, bit1 div_wu, bit2 mod_w, bit3 mod_wu
module div_sequencer (
  input  logic                  clk,
  input  logic                  resetn,
  div_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] src1_q, src1_d;     // original dividend, needed for divide-by-zero
  logic [31:0] src2_q, src2_d;     // original divisor
  logic [31:0] dvd_q, dvd_d;       // magnitude dividend, shifted out MSB first
  logic [31:0] dvs_q, dvs_d;       // magnitude divisor
  logic [31:0] rem_q, rem_d;       // partial remainder (always < divisor)
  logic [31:0] quo_q, quo_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  logic        op_signed;
  logic        op_is_mod;
  logic        accept;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign op_signed = op_q[0] | op_q[2];
  assign op_is_mod = op_q[2] | op_q[3];

  assign bus.in_ready   = (state_q == IDLE) && !bus.cancel;
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = (state_q == DONE) ? result_q : 32'd0;

  // Malformed op encodings are silently ignored so the request never enters.
  assign accept = bus.in_valid && bus.in_ready && $onehot(bus.in_op);

  // One restoring step: bring in the next dividend bit, trial-subtract in 33 bits.
  assign rem_shift = {rem_q, dvd_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  always_comb begin
    q_fix = qneg_q ? (32'd0 - quo_q) : quo_q;
    r_fix = rneg_q ? (32'd0 - rem_q) : rem_q;
    // Divide-by-zero returns all-ones / dividend regardless of signedness.
    if (src2_q == 32'd0) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = src1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.in_op;
          src1_d  = bus.in_src1;
          src2_d  = bus.in_src2;
          state_d = PREP;
        end
      end
      PREP: begin
        // abs(0x80000000) stays 0x80000000, which is the correct magnitude unsigned.
        dvd_d   = (op_signed && src1_q[31]) ? (32'd0 - src1_q) : src1_q;
        dvs_d   = (op_signed && src2_q[31]) ? (32'd0 - src2_q) : src2_q;
        qneg_d  = op_signed && (src1_q[31] ^ src2_q[31]);
        rneg_d  = op_signed && src1_q[31];
        rem_d   = 32'd0;
        quo_d   = 32'd0;
        cnt_d   = 5'd0;
        state_d = CALC;
      end
      CALC: begin
        dvd_d = {dvd_q[30:0], 1'b0};
        if (!rem_diff[32]) begin
          rem_d = rem_diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = op_is_mod ? r_fix : q_fix;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over everything, including a DONE handshake in the same cycle.
    if (bus.cancel) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= 4'd0;
      src1_q   <= 32'd0;
      src2_q   <= 32'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  div_sequencer_if bus ();

  div_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] DIV_W  = 4'b0001;
  localparam logic [3:0] DIV_WU = 4'b0010;
  localparam logic [3:0] MOD_W  = 4'b0100;
  localparam logic [3:0] MOD_WU = 4'b1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    int signed   sa;
    int signed   sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0] || op[2]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return (op[2] || op[3]) ? r : q;
  endfunction

  // Presents one request at a negedge; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    chk({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    logic [31:0] exp;
    int          n;
    bit          seen;
    exp = model(op, a, b);
    send(op, a, b, tag);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      seen = bus.out_valid;
    end
    chk({tag, "/latency"}, n, 32'd34);
    chk({tag, "/result"}, bus.out_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "/hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "/hold_result"}, bus.out_result, exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "/post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "/post_result"}, bus.out_result, 32'd0);
    chk({tag, "/post_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    checks        = 0;
    errors        = 0;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_src1   = 32'd0;
    bus.in_src2   = 32'd0;
    bus.cancel    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst/out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst/out_result", bus.out_result, 32'd0);
    chk("rst/busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst/in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Malformed op encodings are refused
    bus.in_valid = 1'b1;
    bus.in_op    = 4'b0000;
    bus.in_src1  = 32'd9;
    bus.in_src2  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    chk("badop0/busy", {31'd0, bus.busy}, 32'd0);
    chk("badop0/in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_op = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    chk("badop2/busy", {31'd0, bus.busy}, 32'd0);
    chk("badop2/in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;

    // Directed examples
    do_op(DIV_W,  32'd7,          32'd2,          0, "div_w_7_2");
    do_op(MOD_W,  32'hFFFF_FFF9,  32'd2,          0, "mod_w_m7_2");
    do_op(DIV_W,  32'hFFFF_FFF9,  32'd2,          0, "div_w_m7_2");
    do_op(DIV_WU, 32'hFFFF_FFFF,  32'd2,          0, "div_wu_max_2");
    do_op(MOD_WU, 32'hFFFF_FFFF,  32'd2,          0, "mod_wu_max_2");
    do_op(DIV_W,  32'h1234_5678,  32'd0,          0, "div_w_by0");
    do_op(MOD_W,  32'h1234_5678,  32'd0,          0, "mod_w_by0");
    do_op(DIV_WU, 32'h8765_4321,  32'd0,          0, "div_wu_by0");
    do_op(MOD_WU, 32'h8765_4321,  32'd0,          0, "mod_wu_by0");
    do_op(DIV_W,  32'h8000_0000,  32'hFFFF_FFFF,  0, "div_w_ovf");
    do_op(MOD_W,  32'h8000_0000,  32'hFFFF_FFFF,  0, "mod_w_ovf");
    do_op(MOD_W,  32'd7,          32'hFFFF_FFFE,  0, "mod_w_7_m2");

    // Back-pressure: result held while out_ready stays low
    do_op(DIV_WU, 32'd1000,       32'd7,          5, "hold5");

    // Cancel during CALC step 10
    send(DIV_W, 32'd100, 32'd3, "cancel");
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("cancel/pre_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    @(negedge clk);
    chk("cancel/busy", {31'd0, bus.busy}, 32'd0);
    chk("cancel/in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("cancel/out_valid", {31'd0, bus.out_valid}, 32'd0);
    do_op(MOD_W, 32'hFFFF_FF9C, 32'd7, 0, "after_cancel");

    // Cancel wins over out_ready in DONE
    send(DIV_WU, 32'd50, 32'd5, "cancel_done");
    for (int i = 0; i < 34; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("cancel_done/valid", {31'd0, bus.out_valid}, 32'd1);
    bus.cancel    = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel    = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("cancel_done/post_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("cancel_done/post_busy", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of CALC
    send(MOD_WU, 32'hDEAD_BEEF, 32'd13, "rst_mid");
    repeat (6) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_mid/out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid/out_result", bus.out_result, 32'd0);
    chk("rst_mid/busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid/in_ready", {31'd0, bus.in_ready}, 32'd1);
    do_op(DIV_W, 32'hFFFF_F000, 32'd16, 0, "after_rst");

    // Randomized operations against the arithmetic model
    for (int k = 0; k < 24; k++) begin
      rop = 4'b0001 << $urandom_range(0, 3);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'd0 - $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      do_op(rop, ra, rb, $urandom_range(0, 2), $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: resetn  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-003 SHALL have port: in_valid  in  1  EX stage presents a divide/modulo request.
REQ-004 SHALL have port: in_ready  out  1  sequencer can accept a request this cycle.
REQ-005 SHALL have port: in_op  in  4  one-hot {mod_wu, mod_w, div_wu, div_w}, bit0 = div_w.
REQ-006 SHALL have port: in_src1  in  32  dividend (rj value).
REQ-007 SHALL have port: in_src2  in  32  divisor (rk value).
REQ-008 SHALL have port: cancel  in  1  pipeline flush; abandons any in-flight operation.
REQ-009 SHALL have port: out_valid  out  1  result available.
REQ-010 SHALL have port: out_ready  in  1  downstream (MEM) accepts the result.
REQ-011 SHALL have port: out_result  out  32  quotient or remainder, per the latched op.
REQ-012 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with cancel=0.
REQ-015 Accept SHALL occur on an edge where in_valid & in_ready; it latches in_op, in_src1, in_src2 and moves to PREP.
REQ-016 PREP SHALL last 1 cycle: signed ops take absolute values of both operands; record quotient sign = src1[31]^src2[31] and remainder sign = src1[31]; unsigned ops use operands unchanged.
REQ-017 CALC SHALL last exactly 32 cycles via a 5-bit counter starting at 0; one restoring shift-subtract step per cycle, MSB of dividend first; exit to FIX when counter=31.
REQ-018 Each CALC step SHALL use a 33-bit partial remainder compare-subtract; the quotient bit is 1 when the subtract is non-negative.
REQ-019 FIX SHALL last 1 cycle: apply two's-complement negation to the quotient and/or remainder per the recorded signs (signed ops only), then select the quotient for div ops or the remainder for mod ops.
REQ-020 Divisor=0 SHALL yield quotient 0xFFFFFFFF and remainder = original in_src1, for both signed and unsigned ops.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield quotient 0x80000000 and remainder 0.
REQ-022 out_valid SHALL first be 1 exactly 34 cycles after the accepting edge (in DONE).
REQ-023 In DONE, out_valid SHALL be 1 and out_result SHALL be held stable until an edge with out_ready=1, then the FSM SHALL return to IDLE.
REQ-024 No new request SHALL be accepted in the cycle DONE completes; the earliest next accept is in the following IDLE cycle.
REQ-025 cancel=1 on any edge SHALL force IDLE and clear the counter; out_valid SHALL be 0 from the next cycle, and no result is ever delivered for the cancelled request.
REQ-026 When cancel and out_ready are both 1 in DONE, cancel SHALL take priority (FSM to IDLE; the result counts as discarded).
REQ-027 in_op with zero bits or multiple bits set SHALL NOT be accepted: in_ready stays 1 and the FSM stays in IDLE.
REQ-028 out_result SHALL be 0 whenever out_valid=0.

Reset
REQ-029 On resetn=0 at an edge: state=IDLE, counter=0, all internal registers=0, out_valid=0, out_result=0, busy=0; in_ready=1 from the first cycle after reset is released.
REQ-030 Reset SHALL override cancel, in_valid and any in-progress operation, with no partial result emitted.

Verification
REQ-031 div_w 7 / 2 -> out_valid high 34 cycles after accept, out_result=0x00000003.
REQ-032 mod_w 0xFFFFFFF9 (-7) % 2 -> 0xFFFFFFFF; div_w -7 / 2 -> 0xFFFFFFFD.
REQ-033 div_wu 0xFFFFFFFF / 2 -> 0x7FFFFFFF; mod_wu 0xFFFFFFFF % 2 -> 0x00000001.
REQ-034 div_w 0x12345678 / 0 -> 0xFFFFFFFF; mod_w same operands -> 0x12345678; div_w 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-035 cancel pulsed at CALC cycle 10 -> busy=0 and in_ready=1 next cycle, out_valid never asserted; a new request accepted immediately afterward yields its own correct result.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_valid and out_result held stable for those 5 cycles, then IDLE after the out_ready=1 edge; resetn=0 mid-CALC -> all outputs at reset values next cycle.
